// File: rtl/booth_pp_if.sv
// booth_pp_if: valid/ready bus between the Booth partial-product source and the accumulator
interface booth_pp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TERMS  = 12
);
    localparam int TW = 2 * DATA_WIDTH;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_TERMS*TW-1:0] terms_in;
    logic                    clear;
    logic                    out_valid;
    logic                    out_ready;
    logic [TW-1:0]           product;
    logic                    busy;
    modport master (
        output in_valid, terms_in, clear, out_ready,
        input  in_ready, out_valid, product, busy
    );
    modport slave (
        input  in_valid, terms_in, clear, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: sequentially sums a vector of pre-weighted Booth partial products
module booth_pp_accumulator #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_TERMS       = 12,
    parameter int TERMS_PER_CYCLE = 1
) (
    input logic       clk,
    input logic       rst,
    booth_pp_if.slave bus
);
    localparam int TW = 2 * DATA_WIDTH;
    localparam int IW = $clog2(NUM_TERMS + 2);
    localparam logic [IW-1:0] NT   = IW'(NUM_TERMS);
    localparam logic [IW-1:0] STEP = IW'(TERMS_PER_CYCLE);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t                  state_q, state_d;
    logic [NUM_TERMS*TW-1:0] terms_q, terms_d;
    logic [TW-1:0]           acc_q, acc_d;
    logic [TW-1:0]           product_q, product_d;
    logic [TW-1:0]           sum;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    out_valid_q, out_valid_d;
    logic                    accept;
    logic                    last;
    // Handshake qualifiers: a vector is taken only in IDLE, out of reset, and never alongside clear
    always_comb begin
        accept = bus.in_valid && (state_q == IDLE) && !rst && !bus.clear;
        last   = (idx_q + STEP) >= NT;
    end
    // Running sum plus the term(s) addressed by idx; the second term only exists when in range
    always_comb begin
        sum = acc_q;
        for (int i = 0; i < NUM_TERMS; i++)
            if (IW'(i) == idx_q || (TERMS_PER_CYCLE == 2 && IW'(i) == idx_q + IW'(1)))
                sum = sum + terms_q[i*TW +: TW];
    end
    // Next-state: clear aborts ACCUM/DONE, the last group enters DONE, out_ready drains DONE
    always_comb begin
        state_d = (state_q == IDLE)  ? (accept ? ACCUM : IDLE) :
                  (state_q == ACCUM) ? (bus.clear ? IDLE : last ? DONE : ACCUM) :
                  (bus.clear || bus.out_ready) ? IDLE : DONE;
    end
    // Datapath next values: product only moves on DONE entry, partial sums are dropped on clear
    always_comb begin
        terms_d     = accept ? bus.terms_in : terms_q;
        acc_d       = accept ? '0 : (state_q == ACCUM) ? sum : acc_q;
        idx_d       = accept ? '0 : (state_q == ACCUM) ? idx_q + STEP : idx_q;
        product_d   = (state_q == ACCUM && !bus.clear && last) ? sum : product_q;
        out_valid_d = (state_q == ACCUM) ? (!bus.clear && last) :
                      (state_q == DONE)  ? !(bus.clear || bus.out_ready) : 1'b0;
    end
    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            terms_q     <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            terms_q     <= terms_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end
    // Outputs: in_ready is combinational on state and rst only
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && !rst;
        bus.out_valid = out_valid_q;
        bus.product   = product_q;
        bus.busy      = state_q != IDLE;
    end
endmodule
